// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM state encoding, datapath select codes, default width.
package gcd_pkg;

  localparam int GCD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_DIFF = 2'd2
  } sel_t;

endpackage

// File: rtl/gcd_sel_mux.sv
// Next-value select for one operand register: hold, load new operand, or take the difference.
// Purely combinational, zero latency, no backpressure.
module gcd_sel_mux
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] hold_val,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] diff_val,
  output logic [WIDTH-1:0] next_val
);

  always_comb begin
    next_val = hold_val;
    unique case (sel)
      SEL_HOLD: next_val = hold_val;
      SEL_LOAD: next_val = load_val;
      SEL_DIFF: next_val = diff_val;
      default:  next_val = hold_val;
    endcase
  end

endmodule

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine; result appears iter_out+1 cycles after the input handshake.
// Accepts only in IDLE; holds the result in DONE until out_ready, then returns to IDLE.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iter_out,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] gcd_q, iter_q;
  sel_t             sel_a, sel_b;
  logic             accept, step, result_load;
  logic [WIDTH-1:0] result_val;

  // Single comparator and single subtractor; operands are steered so the larger is the minuend.
  logic             a_gt_b;
  logic [WIDTH-1:0] minuend, subtrahend, diff;

  assign a_gt_b     = (a_q > b_q);
  assign minuend    = a_gt_b ? a_q : b_q;
  assign subtrahend = a_gt_b ? b_q : a_q;
  assign diff       = minuend - subtrahend;

  gcd_sel_mux #(.WIDTH(WIDTH)) u_sel_a (
    .sel      (sel_a),
    .hold_val (a_q),
    .load_val (a_in),
    .diff_val (diff),
    .next_val (a_d)
  );

  gcd_sel_mux #(.WIDTH(WIDTH)) u_sel_b (
    .sel      (sel_b),
    .hold_val (b_q),
    .load_val (b_in),
    .diff_val (diff),
    .next_val (b_d)
  );

  always_comb begin
    state_d     = state_q;
    sel_a       = SEL_HOLD;
    sel_b       = SEL_HOLD;
    accept      = 1'b0;
    step        = 1'b0;
    result_load = 1'b0;
    result_val  = a_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          sel_a   = SEL_LOAD;
          sel_b   = SEL_LOAD;
          state_d = CALC;
        end
      end
      CALC: begin
        if (a_q == '0) begin
          result_load = 1'b1;
          result_val  = b_q;
          state_d     = DONE;
        end else if ((b_q == '0) || (a_q == b_q)) begin
          result_load = 1'b1;
          result_val  = a_q;
          state_d     = DONE;
        end else begin
          step = 1'b1;
          if (a_gt_b) sel_a = SEL_DIFF;
          else        sel_b = SEL_DIFF;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      if (accept)                    cnt_q <= '0;
      else if (step && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
      // Result registers only change on entry to DONE, so they persist through IDLE/CALC.
      if (result_load) begin
        gcd_q  <= result_val;
        iter_q <= cnt_q;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign gcd_out   = gcd_q;
  assign iter_out  = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Randomised and directed bench for gcd_engine against a division-based Euclid reference model.
module tb_gcd_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] gcd_out, iter_out;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .iter_out  (iter_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Subtraction steps of subtractive Euclid = sum of division quotients minus one.
  task automatic ref_model(input int a, input int b, output int g, output int it);
    int x, y, t, qsum;
    x = a; y = b; qsum = 0;
    if (x == 0 || y == 0) begin
      g  = (x == 0) ? y : x;
      it = 0;
    end else begin
      while (y != 0) begin
        qsum += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g  = x;
      it = qsum - 1;
      if (it > (1 << W) - 1) it = (1 << W) - 1;
    end
  endtask

  // One transaction: accept, wait for result, optionally stall the consumer, then release.
  task automatic do_op(input string tag, input int a, input int b, input int hold, input bit scramble);
    int g, it, lat;
    bit timed_out;
    ref_model(a, b, g, it);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    a_in     = W'(a);
    b_in     = W'(b);
    out_ready = 1'b0;
    @(posedge clk); #1;
    if (!scramble) in_valid = 1'b0;
    chk({tag, ".busy_after_accept"}, busy, 1);
    chk({tag, ".in_ready_calc"}, in_ready, 0);
    lat = 0;
    timed_out = 1'b0;
    while (!out_valid) begin
      if (scramble) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (lat > 600) begin
        timed_out = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (timed_out) begin
      chk({tag, ".timeout"}, out_valid, 1);
      return;
    end
    chk({tag, ".latency"}, lat, it + 1);
    chk({tag, ".gcd"}, gcd_out, g);
    chk({tag, ".iter"}, iter_out, it);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_gcd"}, gcd_out, g);
      chk({tag, ".hold_iter"}, iter_out, it);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".idle_ready"}, in_ready, 1);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".gcd_kept"}, gcd_out, g);
    chk({tag, ".iter_kept"}, iter_out, it);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.gcd", gcd_out, 0);
    chk("rst.iter", iter_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", in_ready, 1);

    do_op("d48_18", 48, 18, 0, 1'b0);
    do_op("d255_1", 255, 1, 0, 1'b0);
    do_op("d0_37", 0, 37, 0, 1'b0);
    do_op("d37_0", 37, 0, 0, 1'b0);
    do_op("d0_0", 0, 0, 0, 1'b0);
    do_op("d7_7", 7, 7, 0, 1'b0);
    do_op("stall48_18", 48, 18, 3, 1'b0);
    do_op("ignore48_18", 48, 18, 1, 1'b1);

    // Abort a long computation with an asynchronous reset pulse.
    @(negedge clk);
    in_valid = 1'b1; a_in = 8'd200; b_in = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.busy", busy, 0);
    chk("abort.gcd", gcd_out, 0);
    chk("abort.iter", iter_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort.no_result", out_valid, 0);
    end
    do_op("after_abort12_8", 12, 8, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
